// File: rtl/snn_config_loader.sv
// Framed byte-stream loader for the SNN configuration bank: writes land in a shadow
// bank and are committed atomically on a good checksum; READ frames stream the active bank out.
module snn_config_loader #(
  parameter int NUM_BYTES = 80,
  parameter int ADDR_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  input  logic                   frame_abort,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_byte,
  output logic [NUM_BYTES*8-1:0] cfg_data,
  output logic                   cfg_update,
  output logic                   err,
  output logic                   busy
);

  typedef enum logic [2:0] {IDLE, W_ADDR, W_LEN, W_DATA, W_CSUM, R_ADDR, R_LEN, R_SEND} state_t;

  state_t                        state_q, state_d;
  logic [NUM_BYTES-1:0][7:0]     active, shadow;
  logic [ADDR_W-1:0]             addr_q, len_q, ptr_q, cnt_q, rd_idx, rx_a;
  logic [7:0]                    sum_q, rd_byte;
  logic                          abort_now, do_commit, do_reject, op_err, rd_start;

  // addr+len evaluated one bit wider so it cannot wrap past the bank end
  function automatic logic range_ok(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] l);
    return ({1'b0, a} + {1'b0, l}) <= (ADDR_W+1)'(NUM_BYTES);
  endfunction

  assign rx_a      = ADDR_W'(rx_byte);
  assign abort_now = (state_q != IDLE) && frame_abort;
  assign cfg_data  = active;
  assign busy      = (state_q != IDLE);

  // read mux: first byte comes from the latched addr, later ones from ptr+1
  assign rd_idx = (state_q == R_LEN) ? addr_q : ptr_q + 1'b1;
  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_BYTES; k++)
      if (rd_idx == ADDR_W'(k)) rd_byte = active[k];
  end

  always_comb begin
    state_d   = state_q;
    do_commit = 1'b0;
    do_reject = 1'b0;
    op_err    = 1'b0;
    rd_start  = 1'b0;
    if (abort_now) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:   if (rx_valid) begin
                  if (rx_byte == 8'h01)      state_d = W_ADDR;
                  else if (rx_byte == 8'h02) state_d = R_ADDR;
                  else                       op_err  = 1'b1;
                end
        W_ADDR: if (rx_valid) state_d = W_LEN;
        W_LEN:  if (rx_valid) state_d = (rx_byte != 8'h00) ? W_DATA : W_CSUM;
        W_DATA: if (rx_valid && cnt_q == ADDR_W'(1)) state_d = W_CSUM;
        W_CSUM: if (rx_valid) begin
                  state_d = IDLE;
                  if (rx_byte == sum_q && len_q != '0 && range_ok(addr_q, len_q)) do_commit = 1'b1;
                  else do_reject = 1'b1;
                end
        R_ADDR: if (rx_valid) state_d = R_LEN;
        R_LEN:  if (rx_valid) begin
                  if (rx_a != '0 && range_ok(addr_q, rx_a)) begin
                    state_d  = R_SEND;
                    rd_start = 1'b1;
                  end else begin
                    state_d = IDLE;
                    op_err  = 1'b1;
                  end
                end
        R_SEND: if (tx_ready && cnt_q == ADDR_W'(1)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      active     <= '0;
      shadow     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      tx_valid   <= 1'b0;
      tx_byte    <= '0;
      cfg_update <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_update <= do_commit;
      err        <= op_err | do_reject;
      if (abort_now) begin
        shadow   <= active;
        tx_valid <= 1'b0;
      end else begin
        case (state_q)
          W_ADDR: if (rx_valid) begin
                    addr_q <= rx_a;
                    sum_q  <= rx_byte;
                  end
          W_LEN:  if (rx_valid) begin
                    len_q <= rx_a;
                    cnt_q <= rx_a;
                    ptr_q <= addr_q;
                    sum_q <= sum_q + rx_byte;
                  end
          W_DATA: if (rx_valid) begin
                    for (int k = 0; k < NUM_BYTES; k++)
                      if (ptr_q == ADDR_W'(k)) shadow[k] <= rx_byte;
                    ptr_q <= ptr_q + 1'b1;
                    cnt_q <= cnt_q - 1'b1;
                    sum_q <= sum_q + rx_byte;
                  end
          W_CSUM: begin
                    if (do_commit) active <= shadow;
                    if (do_reject) shadow <= active;
                  end
          R_ADDR: if (rx_valid) addr_q <= rx_a;
          R_LEN:  if (rx_valid) begin
                    len_q <= rx_a;
                    if (rd_start) begin
                      ptr_q    <= addr_q;
                      cnt_q    <= rx_a;
                      tx_valid <= 1'b1;
                      tx_byte  <= rd_byte;
                    end
                  end
          R_SEND: if (tx_ready) begin
                    if (cnt_q == ADDR_W'(1)) tx_valid <= 1'b0;
                    else begin
                      ptr_q   <= ptr_q + 1'b1;
                      cnt_q   <= cnt_q - 1'b1;
                      tx_byte <= rd_byte;
                    end
                  end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_config_loader.sv
// Directed bench for snn_config_loader: a frame table with hand-computed outcomes,
// plus readback, abort and reset sequences.
module tb_snn_config_loader;
  localparam int NB = 80;
  localparam int W  = NB*8;

  bit          clk = 1'b0;
  logic        reset, rx_valid, frame_abort, tx_ready;
  logic [7:0]  rx_byte, tx_byte;
  logic        tx_valid, cfg_update, err, busy;
  logic [W-1:0] cfg_data, model;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  snn_config_loader #(.NUM_BYTES(NB), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .frame_abort(frame_abort), .tx_ready(tx_ready), .tx_valid(tx_valid),
    .tx_byte(tx_byte), .cfg_data(cfg_data), .cfg_update(cfg_update),
    .err(err), .busy(busy)
  );

  typedef struct {
    int          n;
    logic [63:0] frm;   // byte 0 in the top bits
    bit          upd;
    bit          er;
    int          nw;
    int          i0;
    logic [7:0]  v0;
    int          i1;
    logic [7:0]  v1;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called on a negedge; returns on the negedge after the byte was sampled
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{6, 64'h010302AA55050000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // bad csum
    vecs[1] = '{5, 64'h0100011112000000, 1, 0, 1, 0, 8'h11, 0, 8'h00};  // no AA/55 leak
    vecs[2] = '{6, 64'h010302AA55040000, 1, 0, 2, 3, 8'hAA, 4, 8'h55};
    vecs[3] = '{6, 64'h014F020102540000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // 79+2 > 80
    vecs[4] = '{6, 64'h014E020102530000, 1, 0, 2, 78, 8'h01, 79, 8'h02}; // 78+2 == 80
    vecs[5] = '{4, 64'h0105000500000000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // len 0
    vecs[6] = '{1, 64'h0700000000000000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // bad opcode
    vecs[7] = '{3, 64'h024F020000000000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // read range
    vecs[8] = '{3, 64'h0200000000000000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // read len 0
    vecs[9] = '{3, 64'h0250010000000000, 0, 1, 0, 0, 8'h00, 0, 8'h00};  // read at 80

    reset = 1'b1; rx_valid = 1'b0; rx_byte = '0; frame_abort = 1'b0; tx_ready = 1'b0;
    model = '0;
    repeat (3) @(negedge clk);
    chk("rst_cfg", cfg_data, '0);
    chk("rst_flags", W'({tx_valid, cfg_update, err, busy}), '0);
    chk("rst_tx_byte", W'(tx_byte), '0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send(vecs[v].frm[63-8*i -: 8]);
        if (i == 0 && vecs[v].n > 1) chk($sformatf("v%0d_busy_rise", v), W'(busy), W'(1));
      end
      if (vecs[v].nw > 0) model[8*vecs[v].i0 +: 8] = vecs[v].v0;
      if (vecs[v].nw > 1) model[8*vecs[v].i1 +: 8] = vecs[v].v1;
      chk($sformatf("v%0d_upd", v), W'(cfg_update), W'(vecs[v].upd));
      chk($sformatf("v%0d_err", v), W'(err), W'(vecs[v].er));
      chk($sformatf("v%0d_cfg", v), cfg_data, model);
      chk($sformatf("v%0d_busy", v), W'(busy), '0);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", v), W'({cfg_update, err, tx_valid}), '0);
    end

    // readback with stalling consumer
    send(8'h02); send(8'h03); send(8'h02);
    chk("rd_first", W'({tx_valid, tx_byte}), W'({1'b1, 8'hAA}));
    @(negedge clk);
    chk("rd_hold0", W'({tx_valid, tx_byte}), W'({1'b1, 8'hAA}));
    tx_ready = 1'b1;
    @(negedge clk);
    chk("rd_second", W'({tx_valid, tx_byte}), W'({1'b1, 8'h55}));
    tx_ready = 1'b0;
    @(negedge clk);
    chk("rd_hold1", W'({tx_valid, tx_byte}), W'({1'b1, 8'h55}));
    tx_ready = 1'b1;
    @(negedge clk);
    chk("rd_done", W'({tx_valid, busy}), '0);

    // full-throughput readback at the bank end
    send(8'h02); send(8'h4E); send(8'h02);
    chk("rdf_b0", W'({tx_valid, tx_byte}), W'({1'b1, 8'h01}));
    @(negedge clk);
    chk("rdf_b1", W'({tx_valid, tx_byte}), W'({1'b1, 8'h02}));
    @(negedge clk);
    chk("rdf_done", W'({tx_valid, busy}), '0);
    tx_ready = 1'b0;

    // abort during readback drops tx_valid
    send(8'h02); send(8'h03); send(8'h02);
    frame_abort = 1'b1;
    @(negedge clk);
    frame_abort = 1'b0;
    chk("rd_abort", W'({tx_valid, busy, err}), '0);

    // abort mid-write discards shadow data; later write commits cleanly
    send(8'h01); send(8'h11); send(8'h02); send(8'hBB);
    frame_abort = 1'b1;
    rx_valid = 1'b1; rx_byte = 8'h44;   // abort wins over a simultaneous byte
    @(negedge clk);
    frame_abort = 1'b0; rx_valid = 1'b0;
    chk("wr_abort", W'({busy, err, cfg_update}), '0);
    chk("wr_abort_cfg", cfg_data, model);
    @(negedge clk);
    chk("wr_abort_quiet", W'({busy, err, cfg_update}), '0);
    send(8'h01); send(8'h10); send(8'h01); send(8'hCC); send(8'hDD);
    model[8*16 +: 8] = 8'hCC;
    chk("post_abort_upd", W'({cfg_update, err}), W'({1'b1, 1'b0}));
    chk("post_abort_cfg", cfg_data, model);

    // reset in the middle of W_DATA
    @(negedge clk);
    send(8'h01); send(8'h00); send(8'h03); send(8'h11);
    chk("mid_busy", W'(busy), W'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_cfg", cfg_data, '0);
    chk("mid_rst_flags", W'({tx_valid, tx_byte, cfg_update, err, busy}), '0);
    reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_config_loader.md
# snn_config_loader

Parametrised successor to the SNN configuration path. It takes a framed byte stream that is already synchronised into the `clk` domain and writes it into a shadow register bank of `NUM_BYTES` bytes. A frame is committed atomically to the active bank only when its checksum and range checks pass. The block also supports partial writes (start address plus length) and handshaked readback of the active bank. The active bank (`cfg_data`) drives the weights, delays, thresholds, divider and debug fields of the SNN core, so the core never sees a half-written configuration.

## Interface
- `NUM_BYTES`, 80, configuration bank size in bytes (1..255).
- `ADDR_W`, 8, address/length byte width; `NUM_BYTES` < 2^`ADDR_W`.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_byte` is valid this cycle.
- `rx_byte`  in  8  received byte.
- `frame_abort`  in  1  synchronised SS-deassert; cancels the current frame.
- `tx_ready`  in  1  consumer accepts `tx_byte` this cycle.
- `tx_valid`  out  1  `tx_byte` holds a readback byte.
- `tx_byte`  out  8  readback byte.
- `cfg_data`  out  `NUM_BYTES`*8  active bank; byte k is `[8k+7:8k]`.
- `cfg_update`  out  1  one-cycle pulse: the active bank has just changed.
- `err`  out  1  one-cycle pulse: frame rejected.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Frame formats:
  - WRITE: `0x01`, addr, len, len data bytes, csum.
  - READ: `0x02`, addr, len.
- csum is the 8-bit sum mod 256 of addr, len and all data bytes.
- States: IDLE, W_ADDR, W_LEN, W_DATA, W_CSUM, R_ADDR, R_LEN, R_SEND.
- IDLE with a byte accepted:
  - `0x01` goes to W_ADDR.
  - `0x02` goes to R_ADDR.
  - Any other byte pulses `err` and stays in IDLE.
- W_ADDR and W_LEN latch their byte and seed the running sum.
- After W_LEN, go to W_DATA if len ≠ 0, otherwise to W_CSUM.
- W_DATA: each byte is written to shadow[ptr] only if ptr < `NUM_BYTES`. `ptr` increments and the byte is added to the sum. After len bytes, go to W_CSUM.
- W_CSUM, on the received byte:
  - Commit when csum matches, len ≠ 0 and addr+len ≤ `NUM_BYTES`; the addition is done at `ADDR_W`+1 bits, no wrap. Commit means active ← shadow.
  - Otherwise pulse `err` and restore shadow ← active.
  - Either way, return to IDLE.
- R_ADDR and R_LEN latch their bytes.
- At the end of R_LEN:
  - If the range is invalid or len = 0, pulse `err` and go to IDLE.
  - Otherwise go to R_SEND with `ptr` = addr.
- R_SEND drives active[ptr]. After the last handshake, return to IDLE.
- `rx_valid` is ignored during R_SEND.
- `frame_abort` high in any non-IDLE state:
  - Next state is IDLE and shadow ← active.
  - No commit, no `err`, and `tx_valid` drops.
  - Abort takes priority over a simultaneous `rx_valid`.
- `reset` wins over everything.
- The shadow bank equals the active bank whenever the state is IDLE.

## Timing
- Reset values: `cfg_data`=0, shadow=0, `cfg_update`=0, `err`=0, `tx_valid`=0, `tx_byte`=0, `busy`=0, state IDLE.
- At most one byte is accepted per cycle; back-to-back `rx_valid` strobes are legal.
- A csum byte accepted in cycle T gives:
  - Pass: `cfg_data` updated at T+1 and `cfg_update`=1 during T+1 only.
  - Fail: `err`=1 during T+1 only.
- Invalid opcode, or READ range failure accepted at T: `err` high during T+1.
- READ len byte accepted at T: `tx_valid` rises at T+1 with byte addr.
- Readback handshake:
  - A byte transfers on a cycle with `tx_valid` and `tx_ready` both high.
  - `tx_byte` is held stable while `tx_valid` is high and `tx_ready` is low.
  - The next byte is presented on the following cycle; full throughput is 1 byte/cycle.
  - `tx_valid` falls the cycle after the last transfer.
- `busy` rises the cycle after the opcode is accepted and falls on return to IDLE.
- `cfg_data` changes only in a `cfg_update` cycle or on reset.

## Test plan
- Reset mid-W_DATA → all outputs zero next cycle. `cfg_data`=0, `busy`=0.
- WRITE `01 03 02 AA 55 04` (`NUM_BYTES`=80) → `cfg_data` byte3=AA and byte4=55 at csum+1, with `cfg_update` one cycle. Other bytes unchanged.
- Same frame with csum `05` → `err` one cycle, `cfg_data` unchanged. Then WRITE `01 00 01 11 12` → only byte0=11 changes; no AA/55 leak from the shadow.
- WRITE `01 4F 02 01 02 54` (addr 79, len 2) → `err`, no `cfg_update`, `cfg_data` unchanged.
- After the commit above, READ `02 03 02` with `tx_ready` alternating 0/1 → the bytes AA then 55, each held until its handshake. Then `tx_valid`=0 and `busy`=0.
- `frame_abort` after `01 03 02 AA` → IDLE, no `err`, no `cfg_update`. A following valid WRITE commits normally.
